// File: rtl/int2fp_cvt.sv
// -----------------------------------------------------------------------------
// int2fp_cvt
// Sequential 32-bit integer to IEEE-754 single-precision converter. It feeds
// the X/Y operand bus of the FP add/sub unit and uses the same timing style:
// normalization shifts one bit per cycle, rounding gets its own cycle, and
// completion is flagged by a one-cycle pulse.
//
// Ports
//   clk     in   1   system clock, rising edge
//   rst     in   1   synchronous active-high reset (wins over everything)
//   Start   in   1   request conversion of X (only honoured while idle)
//   X       in  32   integer operand, captured on the accepted Start edge
//   busy    out  1   high while normalizing or rounding
//   cvtdone out  1   one-cycle completion pulse, FPX valid in the same cycle
//   FPX     out 32   {sign, exp[7:0], frac[22:0]}, held until next completion
//
// Parameter
//   SIGNED  1 = X is two's complement, 0 = X is an unsigned magnitude
// -----------------------------------------------------------------------------
module int2fp_cvt #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [31:0] X,
  output logic        busy,
  output logic        cvtdone,
  output logic [31:0] FPX
);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_NORM = 2'd1;
  localparam logic [1:0] ST_RND  = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic        r_s;
  logic [7:0]  r_e;
  logic [31:0] r_m;
  logic [31:0] r_fpx;
  logic        r_done;

  // Operand preparation for an accepted Start.
  logic        w_neg;
  logic [31:0] w_mag;
  logic        w_accept;

  assign w_neg    = SIGNED & X[31];
  // -2^31 negates to itself, which reads correctly as magnitude 2^31.
  assign w_mag    = w_neg ? (~X + 32'd1) : X;
  assign w_accept = (r_state == ST_WAIT) && Start;

  // Round-to-nearest-even on the normalized magnitude (M[31] is the hidden 1).
  logic [22:0] w_mant;
  logic        w_guard;
  logic        w_sticky;
  logic        w_lsb;
  logic        w_up;
  logic        w_carry;
  logic [22:0] w_frac;
  logic [7:0]  w_exp;

  assign w_mant   = r_m[30:8];
  assign w_guard  = r_m[7];
  assign w_sticky = |r_m[6:0];
  assign w_lsb    = r_m[8];
  assign w_up     = w_guard & (w_sticky | w_lsb);
  // An all-ones mantissa rounding up wraps to zero and bumps the exponent.
  assign w_carry  = w_up & (&w_mant);
  assign w_frac   = w_up ? (w_mant + 23'd1) : w_mant;
  assign w_exp    = r_e + {7'd0, w_carry};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. A zero operand completes directly from Wait.
  always_comb begin
    w_state_next = ST_WAIT;
    case (r_state)
      ST_WAIT: w_state_next = (Start && (X != 32'd0)) ? ST_NORM : ST_WAIT;
      ST_NORM: w_state_next = r_m[31] ? ST_RND : ST_NORM;
      ST_RND:  w_state_next = ST_WAIT;
      default: w_state_next = ST_WAIT;
    endcase
  end

  // Outputs.
  always_comb begin
    busy    = (r_state != ST_WAIT);
    cvtdone = r_done;
    FPX     = r_fpx;
  end

  // Datapath. s/e/M only change on an accepted Start or during Norm, so a
  // Start or X change while busy cannot disturb a conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= 1'b0;
      r_e    <= 8'd0;
      r_m    <= 32'd0;
      r_fpx  <= 32'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_WAIT: begin
          if (w_accept) begin
            if (X == 32'd0) begin
              r_fpx  <= 32'h0000_0000;
              r_done <= 1'b1;
            end else begin
              r_s <= w_neg;
              r_m <= w_mag;
              r_e <= 8'd158;
            end
          end
        end
        ST_NORM: begin
          if (!r_m[31]) begin
            r_m <= {r_m[30:0], 1'b0};
            r_e <= r_e - 8'd1;
          end
        end
        ST_RND: begin
          r_fpx  <= {r_s, w_exp, w_frac};
          r_done <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int2fp_cvt.sv
// -----------------------------------------------------------------------------
// tb_int2fp_cvt
// Directed, table-driven bench for int2fp_cvt. A signed and an unsigned
// instance run side by side on the same stimulus; each table row carries the
// expected word and latency (edges after the Start edge) for both.
// -----------------------------------------------------------------------------
module tb_int2fp_cvt;

  logic        clk;
  logic        rst;
  logic        Start;
  logic [31:0] X;
  logic        busy_s, busy_u;
  logic        done_s, done_u;
  logic [31:0] fpx_s, fpx_u;

  int2fp_cvt #(.SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .Start(Start), .X(X),
    .busy(busy_s), .cvtdone(done_s), .FPX(fpx_s)
  );

  int2fp_cvt #(.SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .Start(Start), .X(X),
    .busy(busy_u), .cvtdone(done_u), .FPX(fpx_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] fs;
    int          ls;
    logic [31:0] fu;
    int          lu;
  } vec_t;

  vec_t vecs [12];

  int n_total = 0;
  int n_pass  = 0;

  // Observation results.
  int          lat_s, lat_u;
  int          nd_s, nd_u;
  logic [31:0] res_s, res_u;
  bit          bz_s, bz_u;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic sample(input int k);
    if (busy_s) bz_s = 1'b1;
    if (busy_u) bz_u = 1'b1;
    if (done_s) begin
      nd_s++;
      res_s = fpx_s;
      if (lat_s < 0) lat_s = k;
    end
    if (done_u) begin
      nd_u++;
      res_u = fpx_u;
      if (lat_u < 0) lat_u = k;
    end
  endtask

  task automatic clear_obs();
    lat_s = -1; lat_u = -1; nd_s = 0; nd_u = 0;
    res_s = 32'hX; res_u = 32'hX; bz_s = 1'b0; bz_u = 1'b0;
  endtask

  // Drive Start for exactly one edge (E0); returns #1 after E0.
  task automatic start_op(input logic [31:0] x);
    @(negedge clk);
    X = x;
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  // Sample at k=0 (just after E0) and after each of the next ncyc edges.
  task automatic observe(input int ncyc);
    clear_obs();
    sample(0);
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      #1;
      sample(k);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0001, 32'h3F80_0000, 33, 32'h3F80_0000, 33};
    vecs[1]  = '{32'hFFFF_FFFF, 32'hBF80_0000, 33, 32'h4F80_0000, 2};
    vecs[2]  = '{32'h0000_0000, 32'h0000_0000, 0,  32'h0000_0000, 0};
    vecs[3]  = '{32'h7FFF_FFFF, 32'h4F00_0000, 3,  32'h4F00_0000, 3};
    vecs[4]  = '{32'd16777217,  32'h4B80_0000, 9,  32'h4B80_0000, 9};
    vecs[5]  = '{32'd16777219,  32'h4B80_0002, 9,  32'h4B80_0002, 9};
    vecs[6]  = '{32'h8000_0000, 32'hCF00_0000, 2,  32'h4F00_0000, 2};
    vecs[7]  = '{32'd1000,      32'h447A_0000, 24, 32'h447A_0000, 24};
    vecs[8]  = '{32'd5,         32'h40A0_0000, 31, 32'h40A0_0000, 31};
    vecs[9]  = '{32'd3,         32'h4040_0000, 32, 32'h4040_0000, 32};
    vecs[10] = '{32'hFFFF_FFFB, 32'hC0A0_0000, 31, 32'h4F80_0000, 2};
    vecs[11] = '{32'd16777216,  32'h4B80_0000, 9,  32'h4B80_0000, 9};

    rst = 1'b1;
    Start = 1'b0;
    X = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy_s", {31'd0, busy_s}, 32'd0);
    chk("reset busy_u", {31'd0, busy_u}, 32'd0);
    chk("reset done_s", {31'd0, done_s}, 32'd0);
    chk("reset done_u", {31'd0, done_u}, 32'd0);
    chk("reset fpx_s", fpx_s, 32'd0);
    chk("reset fpx_u", fpx_u, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].x);
      observe(40);
      $display("vec %0d X=%h: S fpx=%h lat=%0d | U fpx=%h lat=%0d",
               i, vecs[i].x, res_s, lat_s, res_u, lat_u);
      chk($sformatf("v%0d fpx_s", i), res_s, vecs[i].fs);
      chk($sformatf("v%0d lat_s", i), 32'(lat_s), 32'(vecs[i].ls));
      chk($sformatf("v%0d ndone_s", i), 32'(nd_s), 32'd1);
      chk($sformatf("v%0d busy_s", i), {31'd0, bz_s}, {31'd0, vecs[i].x != 32'd0});
      chk($sformatf("v%0d fpx_u", i), res_u, vecs[i].fu);
      chk($sformatf("v%0d lat_u", i), 32'(lat_u), 32'(vecs[i].lu));
      chk($sformatf("v%0d ndone_u", i), 32'(nd_u), 32'd1);
      chk($sformatf("v%0d busy_u", i), {31'd0, bz_u}, {31'd0, vecs[i].x != 32'd0});
    end

    // Start pulses and X changes during a busy conversion must be ignored.
    start_op(32'd1000);
    clear_obs();
    sample(0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k >= 5 && k <= 7) begin
        Start = 1'b1;
        X = 32'd5;
      end else begin
        Start = 1'b0;
        X = 32'(k * 777);
      end
      @(posedge clk);
      #1;
      sample(k);
    end
    Start = 1'b0;
    $display("ignore-start: S fpx=%h lat=%0d n=%0d | U fpx=%h lat=%0d n=%0d",
             res_s, lat_s, nd_s, res_u, lat_u, nd_u);
    chk("ignore fpx_s", res_s, 32'h447A_0000);
    chk("ignore lat_s", 32'(lat_s), 32'd24);
    chk("ignore ndone_s", 32'(nd_s), 32'd1);
    chk("ignore fpx_u", res_u, 32'h447A_0000);
    chk("ignore ndone_u", 32'(nd_u), 32'd1);

    // Back-to-back: Start raised in the cvtdone cycle itself.
    start_op(32'd1000);
    clear_obs();
    for (int k = 1; k <= 40 && nd_s == 0; k++) begin
      @(posedge clk);
      #1;
      sample(k);
    end
    chk("b2b first done", 32'(nd_s), 32'd1);
    X = 32'd5;
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    observe(40);
    $display("back-to-back: S fpx=%h lat=%0d | U fpx=%h lat=%0d", res_s, lat_s, res_u, lat_u);
    chk("b2b fpx_s", res_s, 32'h40A0_0000);
    chk("b2b lat_s", 32'(lat_s), 32'd31);
    chk("b2b fpx_u", res_u, 32'h40A0_0000);
    chk("b2b lat_u", 32'(lat_u), 32'd31);

    // Reset in the middle of a long conversion abandons it.
    start_op(32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst busy_s", {31'd0, busy_s}, 32'd0);
    chk("midrst fpx_s", fpx_s, 32'd0);
    chk("midrst done_s", {31'd0, done_s}, 32'd0);
    chk("midrst busy_u", {31'd0, busy_u}, 32'd0);
    chk("midrst fpx_u", fpx_u, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    observe(40);
    $display("after mid reset: S n=%0d busy=%0d | U n=%0d busy=%0d", nd_s, bz_s, nd_u, bz_u);
    chk("midrst no done_s", 32'(nd_s), 32'd0);
    chk("midrst no done_u", 32'(nd_u), 32'd0);
    chk("midrst idle_s", {31'd0, bz_s}, 32'd0);
    start_op(32'd3);
    observe(40);
    $display("post-reset X=3: S fpx=%h lat=%0d | U fpx=%h lat=%0d", res_s, lat_s, res_u, lat_u);
    chk("post fpx_s", res_s, 32'h4040_0000);
    chk("post lat_s", 32'(lat_s), 32'd32);
    chk("post fpx_u", res_u, 32'h4040_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
